// File: rtl/multiword_add_sequencer.sv
// -----------------------------------------------------------------------------
// multiword_add_sequencer
//
// Performs a (16*WORDS)-bit add or subtract by time-multiplexing one external
// 16-bit adder with carry-in/carry-out. Operands are latched on Start, then
// fed to the adder one 16-bit chunk per cycle, least-significant chunk first.
// The adder's carry-out is registered and chained into the next chunk's cin.
// Subtraction is done as A + ~B + 1: B is inverted at capture and the initial
// carry is seeded with 1.
//
// Ports
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous, active-high reset
//   Start     in   operation request, sampled only in IDLE
//   Sub       in   0 = A+B, 1 = A-B (sampled with Start)
//   A, B      in   W-bit operands (sampled with Start)
//   Busy      out  high while an operation is running and in its Done cycle
//   Done      out  one-cycle completion pulse
//   Sum       out  W-bit result register (partial while Busy)
//   CarryOut  out  final adder carry (for Sub: 1 = no borrow)
//   Overflow  out  two's-complement signed overflow of the operation
//   AddA      out  to external adder dataa
//   AddB      out  to external adder datab
//   AddCin    out  to external adder cin
//   AddS      in   from external adder result (combinational)
//   AddCout   in   from external adder carry-out
// -----------------------------------------------------------------------------
module multiword_add_sequencer #(
   parameter  int WORDS = 4,
   localparam int W     = 16 * WORDS
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Sub,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   output logic          Busy,
   output logic          Done,
   output logic [W-1:0]  Sum,
   output logic          CarryOut,
   output logic          Overflow,
   output logic [15:0]   AddA,
   output logic [15:0]   AddB,
   output logic          AddCin,
   input  logic [15:0]   AddS,
   input  logic          AddCout
);

   localparam int               IDX_W    = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q,   idx_d;
   logic              carry_q, carry_d;
   logic [W-1:0]      a_q,     a_d;
   logic [W-1:0]      b_q,     b_d;
   logic [W-1:0]      sum_q,   sum_d;
   logic              cout_q,  cout_d;
   logic              ovf_q,   ovf_d;

   wire last_chunk = (idx_q == LAST_IDX);

   // --------------------------------------------------------------------------
   // State register and datapath registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   // NOTE: the operand registers are reset along with the rest of the state so
   // no stale operand can ever reach the adder ports after a reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every signal assigned in a combinational block gets a default at the
   // top; a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (Start)      state_d = ST_RUN;
         ST_RUN:  if (last_chunk) state_d = ST_DONE;
         ST_DONE:                 state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath next values
   // --------------------------------------------------------------------------
   always_comb begin
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               a_d     = A;
               b_d     = Sub ? ~B : B;   // A - B == A + ~B + 1
               carry_d = Sub;            // the "+1" of the two's complement
               idx_d   = '0;
               sum_d   = '0;
            end
         end
         ST_RUN: begin
            sum_d[16*idx_q +: 16] = AddS;
            carry_d               = AddCout;
            idx_d                 = idx_q + 1'b1;
            if (last_chunk) begin
               cout_d = AddCout;
               // Operands share a sign but the result sign differs. b_q already
               // holds ~B for subtract, so this covers both operations.
               ovf_d  = (a_q[W-1] == b_q[W-1]) && (AddS[15] != a_q[W-1]);
            end
         end
         default: ;
      endcase
   end

   // --------------------------------------------------------------------------
   // Outputs: purely from registers, no path from A, B or Start
   // --------------------------------------------------------------------------
   always_comb begin
      Busy   = (state_q != ST_IDLE);
      Done   = (state_q == ST_DONE);
      AddA   = '0;
      AddB   = '0;
      AddCin = 1'b0;
      if (state_q == ST_RUN) begin
         AddA   = a_q[16*idx_q +: 16];
         AddB   = b_q[16*idx_q +: 16];
         AddCin = carry_q;
      end
   end

   assign Sum      = sum_q;
   assign CarryOut = cout_q;
   assign Overflow = ovf_q;

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
Sequencer that performs WORDS×16-bit add/subtract by time-multiplexing the team's 16-bit carry-in/carry-out adder (AlteraAdder). It slices wide operands into 16-bit chunks, LS chunk first, and drives the adder's dataa/datab/cin. It captures result/cout and chains the carry through a register. The adder instance sits outside this block and connects to the Add* ports.

Parameters:
WORDS, 4, number of 16-bit chunks; operand width W = 16*WORDS; legal range 2..16.

Ports:
Clock  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request; sampled only in IDLE.
Sub  input  1  0 = A+B, 1 = A-B; sampled with Start.
A  input  W  operand A; sampled with Start.
B  input  W  operand B; sampled with Start.
Busy  output  1  high in RUN and DONE.
Done  output  1  one-cycle pulse in DONE.
Sum  output  W  result register.
CarryOut  output  1  final adder carry (Sub: 1 = no borrow).
Overflow  output  1  two's-complement signed overflow.
AddA  output  16  to adder dataa.
AddB  output  16  to adder datab.
AddCin  output  1  to adder cin.
AddS  input  16  from adder result (combinational).
AddCout  input  1  from adder cout.

Behaviour:
- Reset (async, any state):
  - state = IDLE; chunk index = 0; carry reg = 0.
  - Sum = 0, CarryOut = 0, Overflow = 0, Busy = 0, Done = 0.
  - Latched operands = 0.
  - Reset in RUN aborts the operation; no Done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE, Start = 1 at an edge:
  - Areg <= A.
  - Breg <= Sub ? ~B : B.
  - carry reg <= Sub.
  - index <= 0.
  - Sum <= 0.
  - Go to RUN.
- IDLE, Start = 0: hold all outputs.
- RUN:
  - Drive AddA = Areg[16*idx +: 16], AddB = Breg[16*idx +: 16], AddCin = carry reg.
  - These are combinational from registers only, with no path from A, B or Start.
  - At each edge: Sum[16*idx +: 16] <= AddS; carry reg <= AddCout; idx <= idx+1.
  - At the edge where idx == WORDS-1:
    - CarryOut <= AddCout.
    - Overflow <= (Areg[W-1] == Breg[W-1]) && (AddS[15] != Areg[W-1]).
    - Go to DONE.
- DONE: Done = 1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: Start sampled at edge n → Done high during the cycle after edge n+WORDS, i.e. WORDS+1 cycles after acceptance.
  - Back-to-back: a new Start is accepted at the edge leaving DONE+1 (IDLE).
  - Throughput is one operation per WORDS+2 cycles.
- In IDLE and DONE, AddA = 0, AddB = 0, AddCin = 0.
- Start while Busy = 1: ignored. A, B and Sub changes while Busy have no effect.
- Sum may show partial chunks while Busy. Sum, CarryOut and Overflow are valid from the Done cycle and hold until the next Start is accepted.
- The adder is treated as purely combinational; no wait states.
- Arithmetic: {CarryOut, Sum} == A + B, or == A + ~B + 1 when Sub = 1 (mod 2^(W+1) semantics of the ripple).

Test Plan:
(WORDS=4, with a behavioural 16-bit adder model on the Add* ports.)
- Add, single carry: A=0x0000_0000_0000_FFFF, B=0x1, Sub=0 → Sum=0x0000_0000_0001_0000, CarryOut=0, Overflow=0. Done is high exactly 5 cycles after the Start edge; Busy is high 5 cycles.
- Full ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 → Sum=0, CarryOut=1, Overflow=0. AddCin=1 on chunks 1..3.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 → Sum=0x8000_0000_0000_0000, Overflow=1, CarryOut=0.
- Subtract:
  - A=5, B=7, Sub=1 → Sum=0xFFFF_FFFF_FFFF_FFFE, CarryOut=0, Overflow=0.
  - Then A=7, B=5 → Sum=0x2, CarryOut=1.
  - Then A=0x8000_0000_0000_0000, B=1 → Overflow=1.
- Control hazards:
  - Start held high with changing A/B during Busy → only the first operands are used; exactly one Done pulse.
  - Reset asserted mid-RUN (chunk 2) → Busy, Done, Sum and Add* all read 0 immediately, before the next edge, and no Done follows.
  - A subsequent Start completes correctly.
- Random: 200 back-to-back operations with random A, B, Sub → {CarryOut, Sum} matches the golden model and Overflow matches the signed check. Assert every result.
